goertzel_frame_ctrl: RTL and testbench
======================================

Name: goertzel_frame_ctrl

Overview:
- Frame sequencer for the fixed-bin Goertzel IIR core. It gates a streaming sample source into the core in frames of exactly N accepted samples, and pulses the core clear at each frame start.
- It captures each frame's Re/Im result into a one-entry valid/ready output buffer.
- It runs a programmed number of frames or runs continuously, and reports done, overrun and timeout status.
- It sits between the ADC sample stream and the Goertzel core; the core's own free-running counter is replaced by this block's control.

Parameters:
- IW, 12, sample width, A(1,10) signed.
- OW, 32, result width per component.
- N, 126, samples per frame.
- FW, 8, width of frame-count register.
- CORE_TO, 8, max cycles to wait for core result after last sample.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  start request (honoured in IDLE only).
- i_abort  in  1  abort current run.
- i_frames  in  FW  frames to run; 0 = continuous; latched on start.
- i_sample  in  IW  sample data.
- i_sample_valid  in  1  sample present.
- o_sample_ready  out  1  sample accepted when valid&ready.
- o_core_clr  out  1  one-cycle core delay-line clear.
- o_core_en  out  1  core accumulate enable.
- o_core_sample  out  IW  sample forwarded to core.
- o_core_last  out  1  marks Nth sample of frame.
- i_core_valid  in  1  core result strobe.
- i_core_re  in  OW  core Re{X(k)}.
- i_core_im  in  OW  core Im{X(k)}.
- o_res_valid  out  1  result buffer full.
- i_res_ready  in  1  consumer pop.
- o_res_re  out  OW  buffered Re.
- o_res_im  out  OW  buffered Im.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse after final frame captured.
- o_overrun  out  1  sticky: a result was dropped.
- o_timeout  out  1  sticky: core result did not arrive within CORE_TO cycles.

Behaviour:
- States: IDLE, CLEAR, ACCUM, WAIT_RES.
- Reset (i_rst=1) forces IDLE and clears all outputs to 0, including o_res_re/o_res_im, both sticky flags and all counters.
- IDLE: on i_start & !i_abort, latch i_frames, zero frame_cnt, and go to CLEAR.
- CLEAR: o_core_clr=1 for exactly one cycle, sample counter n=0, then ACCUM.
- ACCUM:
  - o_sample_ready=1.
  - On valid&ready: o_core_en=1 and o_core_sample=i_sample in the same cycle (combinational pass-through, zero latency), and n increments.
  - o_core_last=1 with the sample where n==N-1; on that sample, go to WAIT_RES and reset n to 0.
  - Cycles without i_sample_valid do not advance n.
- WAIT_RES:
  - o_sample_ready=0; the timeout counter runs.
  - On i_core_valid: capture the result (see buffer rules) and increment frame_cnt.
  - If i_frames!=0 and frame_cnt+1==i_frames: pulse o_done and go to IDLE.
  - Otherwise go to CLEAR.
  - If CORE_TO cycles elapse with no i_core_valid: set o_timeout and go to IDLE (no o_done).
- Result buffer:
  - Pop on o_res_valid&i_res_ready.
  - Capture when empty, or on the same cycle as a pop: load re/im and set o_res_valid.
  - Capture while full and not popping: drop the new result, keep the old one, set o_overrun.
  - i_core_valid outside WAIT_RES is ignored.
- Abort:
  - i_abort in any non-IDLE state → next cycle IDLE with o_core_clr=1 for that cycle.
  - A partial frame is discarded; o_res_valid and its contents are retained.
  - Sticky flags are unchanged.
  - Abort wins over a simultaneous start, i_core_valid or last sample.
- i_start while busy is ignored; i_frames changes mid-run have no effect.
- Continuous mode (i_frames==0): frame_cnt wraps at 2^FW silently; o_done never pulses.
- Sticky flags clear only on i_rst or on an accepted i_start.
- Frame boundary: one CLEAR cycle plus the WAIT_RES cycles lie between the last sample of frame f and the first sample of frame f+1. The source must tolerate ready deasserting.

Decomposition:
- Package goertzel_pkg holds:
  - the state enum encoding (IDLE=0, CLEAR=1, ACCUM=2, WAIT_RES=3);
  - default N, IW, OW;
  - the SIN constant 8'b01101111 shared with the core.
- One sub-module is natural: goertzel_res_buf (one-entry valid/ready buffer with overrun detect).

Test Plan:
- i_frames=2, samples always valid, core returns valid 2 cycles after last with re=5, im=7 then re=9, im=11, ready=1 → two o_res_valid pulses with those values; o_done once, after the 2nd capture; 252 accepted samples; o_core_clr pulsed twice.
- Gapped input (valid every 3rd cycle), i_frames=1 → o_core_last on the 126th accepted sample only; n does not advance on idle cycles.
- i_res_ready=0, i_frames=3 → first result retained; o_overrun=1 after 2nd capture; o_res_re still equals the frame-1 value.
- i_abort at accepted sample 60 → IDLE next cycle with o_core_clr=1; o_busy=0; no o_done; restart yields a full 126-sample frame.
- Core never responds → o_timeout=1 exactly CORE_TO cycles after o_core_last; state IDLE; i_start clears o_timeout.
- i_rst asserted mid-ACCUM with o_res_valid=1 → all outputs 0 next cycle; i_start with i_abort in same cycle → stays IDLE.

Source files
------------

// File: rtl/goertzel_pkg.sv
// Shared definitions for the fixed-bin Goertzel core and its frame sequencer.
//   - FSM state encoding of the frame sequencer
//   - default frame length and datapath widths
//   - SIN twiddle constant used by the core
package goertzel_pkg;

    // Frame sequencer states (2-bit encoding kept stable for debug tooling).
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLEAR    = 2'd1;
    localparam logic [1:0] ST_ACCUM    = 2'd2;
    localparam logic [1:0] ST_WAIT_RES = 2'd3;

    localparam int GZ_N  = 126;  // samples per frame
    localparam int GZ_IW = 12;   // sample width, A(1,10) signed
    localparam int GZ_OW = 32;   // result width per component

    // Twiddle sine term shared with the core.
    localparam logic [7:0] GZ_SIN = 8'b01101111;

    function automatic logic st_busy(input logic [1:0] st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/goertzel_res_buf.sv
// One-entry valid/ready result buffer with overrun detection.
//
// Handshake: o_valid stays high until the consumer pops with
// o_valid & i_ready; o_re/o_im are stable while o_valid is high.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clr_sticky      clears the overrun flag (accepted start)
//   i_cap             capture strobe for i_re/i_im
//   i_re, i_im        result to capture
//   i_ready           consumer ready
//   o_valid           buffer full
//   o_re, o_im        buffered result
//   o_overrun         sticky: a capture was dropped
module goertzel_res_buf
#(
    parameter int OW = 32
)
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr_sticky,
    input  logic          i_cap,
    input  logic [OW-1:0] i_re,
    input  logic [OW-1:0] i_im,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [OW-1:0] o_re,
    output logic [OW-1:0] o_im,
    output logic          o_overrun
);

    logic pop;
    assign pop = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_re      <= '0;
            o_im      <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (i_clr_sticky) begin
                o_overrun <= 1'b0;
            end
            // A pop in the same cycle frees the slot for the new result.
            if (i_cap && (!o_valid || pop)) begin
                o_valid <= 1'b1;
                o_re    <= i_re;
                o_im    <= i_im;
            end else if (i_cap) begin
                // Full and not draining: keep the old entry, flag the loss.
                o_overrun <= 1'b1;
            end else if (pop) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/goertzel_frame_ctrl.sv
// Frame sequencer for the fixed-bin Goertzel core.
//
// Gates a streaming sample source into the core in frames of exactly N
// accepted samples, clears the core at each frame start, and captures each
// frame's Re/Im result into a one-entry output buffer.
//
// Handshakes: a sample transfers on i_sample_valid & o_sample_ready; a
// result leaves the buffer on o_res_valid & i_res_ready. i_core_valid is a
// one-cycle strobe with no back-pressure.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_start, i_abort, i_frames        run control (i_frames=0: continuous)
//   i_sample, i_sample_valid,
//   o_sample_ready                    sample stream input
//   o_core_clr, o_core_en,
//   o_core_sample, o_core_last        core control / data
//   i_core_valid, i_core_re, i_core_im core result
//   o_res_valid, i_res_ready,
//   o_res_re, o_res_im                buffered result output
//   o_busy, o_done, o_overrun,
//   o_timeout                         status
module goertzel_frame_ctrl
    import goertzel_pkg::*;
#(
    parameter int IW      = GZ_IW,
    parameter int OW      = GZ_OW,
    parameter int N       = GZ_N,
    parameter int FW      = 8,
    parameter int CORE_TO = 8
)
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [FW-1:0] i_frames,
    input  logic [IW-1:0] i_sample,
    input  logic          i_sample_valid,
    output logic          o_sample_ready,
    output logic          o_core_clr,
    output logic          o_core_en,
    output logic [IW-1:0] o_core_sample,
    output logic          o_core_last,
    input  logic          i_core_valid,
    input  logic [OW-1:0] i_core_re,
    input  logic [OW-1:0] i_core_im,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [OW-1:0] o_res_re,
    output logic [OW-1:0] o_res_im,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_overrun,
    output logic          o_timeout
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (CORE_TO > 2) ? $clog2(CORE_TO) : 1;

    logic [1:0]    state_q, state_d;
    logic [NW-1:0] n_q;
    logic [FW-1:0] frames_q;
    logic [FW-1:0] frame_cnt_q;
    logic [FW-1:0] frame_nxt;
    logic [TW-1:0] to_q;
    logic          abort_clr_q;
    logic          done_q;
    logic          timeout_q;

    logic abort_hit, start_ok, accept, last_hit, core_hit, final_frame, to_expire;

    always_comb begin
        abort_hit   = st_busy(state_q) && i_abort;
        start_ok    = (state_q == ST_IDLE) && i_start && !i_abort;
        // Abort wins over a sample, the last sample and a core result.
        accept      = (state_q == ST_ACCUM) && !i_abort && i_sample_valid;
        last_hit    = accept && (n_q == NW'(N - 1));
        core_hit    = (state_q == ST_WAIT_RES) && !i_abort && i_core_valid;
        frame_nxt   = frame_cnt_q + 1'b1;
        final_frame = (frames_q != '0) && (frame_nxt == frames_q);
        // to_q counts cycles since the last sample (1 in the first WAIT_RES
        // cycle), so o_timeout rises exactly CORE_TO cycles after o_core_last.
        to_expire   = (state_q == ST_WAIT_RES) && !i_abort && !i_core_valid
                      && (to_q == TW'(CORE_TO - 1));
    end

    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (start_ok) state_d = ST_CLEAR;
                ST_CLEAR:    state_d = ST_ACCUM;
                ST_ACCUM:    if (last_hit) state_d = ST_WAIT_RES;
                ST_WAIT_RES: begin
                    if (core_hit)       state_d = final_frame ? ST_IDLE : ST_CLEAR;
                    else if (to_expire) state_d = ST_IDLE;
                end
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            frames_q    <= '0;
            frame_cnt_q <= '0;
            to_q        <= '0;
            abort_clr_q <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            abort_clr_q <= abort_hit;
            done_q      <= core_hit && final_frame;
            if (start_ok) begin
                frames_q    <= i_frames;
                frame_cnt_q <= '0;
                timeout_q   <= 1'b0;
            end
            case (state_q)
                ST_CLEAR: n_q <= '0;
                ST_ACCUM: begin
                    if (last_hit) begin
                        n_q  <= '0;
                        to_q <= TW'(1);
                    end else if (accept) begin
                        n_q <= n_q + 1'b1;
                    end
                end
                ST_WAIT_RES: begin
                    if (core_hit) begin
                        frame_cnt_q <= frame_nxt;  // wraps silently in continuous mode
                    end else if (to_expire) begin
                        timeout_q <= 1'b1;
                    end else if (!i_abort) begin
                        to_q <= to_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    goertzel_res_buf #(.OW(OW)) u_res_buf (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr_sticky (start_ok),
        .i_cap        (core_hit),
        .i_re         (i_core_re),
        .i_im         (i_core_im),
        .i_ready      (i_res_ready),
        .o_valid      (o_res_valid),
        .o_re         (o_res_re),
        .o_im         (o_res_im),
        .o_overrun    (o_overrun)
    );

    assign o_sample_ready = (state_q == ST_ACCUM) && !i_abort;
    assign o_core_en      = accept;
    assign o_core_sample  = accept ? i_sample : '0;
    assign o_core_last    = last_hit;
    // Clear on frame start, and in the IDLE cycle that follows an abort.
    assign o_core_clr     = (state_q == ST_CLEAR) || abort_clr_q;
    assign o_busy         = st_busy(state_q);
    assign o_done         = done_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// Directed bench for goertzel_frame_ctrl: core responder model, negedge
// monitor with result scoreboard, and per-scenario checks.
module tb_goertzel_frame_ctrl;

    localparam int IW = 12;
    localparam int OW = 32;
    localparam int N  = 126;
    localparam int FW = 8;
    localparam int CORE_TO = 8;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_abort;
    logic [FW-1:0] i_frames;
    logic [IW-1:0] i_sample;
    logic          i_sample_valid, o_sample_ready;
    logic          o_core_clr, o_core_en, o_core_last;
    logic [IW-1:0] o_core_sample;
    logic          i_core_valid;
    logic [OW-1:0] i_core_re, i_core_im;
    logic          o_res_valid, i_res_ready;
    logic [OW-1:0] o_res_re, o_res_im;
    logic          o_busy, o_done, o_overrun, o_timeout;

    goertzel_frame_ctrl #(.IW(IW), .OW(OW), .N(N), .FW(FW), .CORE_TO(CORE_TO)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_frames       (i_frames),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .o_core_clr     (o_core_clr),
        .o_core_en      (o_core_en),
        .o_core_sample  (o_core_sample),
        .o_core_last    (o_core_last),
        .i_core_valid   (i_core_valid),
        .i_core_re      (i_core_re),
        .i_core_im      (i_core_im),
        .o_res_valid    (o_res_valid),
        .i_res_ready    (i_res_ready),
        .o_res_re       (o_res_re),
        .o_res_im       (o_res_im),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_overrun      (o_overrun),
        .o_timeout      (o_timeout)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [63:0] exp_q[$];   // expected {re, im} popped from the result buffer
    logic [63:0] rsp_q[$];   // {re, im} the core model returns, frame by frame
    logic        ovr_log[$]; // o_overrun one cycle after each core response
    int core_delay = 2;      // 0: core never answers

    int cyc = 0, clr_cnt = 0, acc_cnt = 0, frame_acc = 0, last_cnt = 0;
    int done_cnt = 0, pop_cnt = 0, done_pops = -1, last_cyc = -1, to_cyc = -1;
    logic to_prev = 1'b0;

    task automatic clear_stats();
        clr_cnt = 0; acc_cnt = 0; last_cnt = 0; done_cnt = 0;
        pop_cnt = 0; done_pops = -1; last_cyc = -1; to_cyc = -1;
        ovr_log.delete();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        cyc++;
        if (o_core_clr) begin
            clr_cnt++;
            frame_acc = 0;
        end
        if (o_core_en) begin
            acc_cnt++;
            frame_acc++;
            check_vec("core_sample", 64'(o_core_sample), 64'(i_sample));
        end
        if (o_core_last) begin
            last_cnt++;
            last_cyc = cyc;
            check_vec("last_pos", 64'(frame_acc), 64'(N));
        end
        if (o_res_valid && i_res_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                check_vec("pop_unexpected", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_vec("res_re", 64'(o_res_re), 64'(e[63:32]));
                check_vec("res_im", 64'(o_res_im), 64'(e[31:0]));
            end
        end
        if (o_done) begin
            done_cnt++;
            done_pops = pop_cnt;
        end
        if (o_timeout && !to_prev) to_cyc = cyc;
        to_prev = o_timeout;
    end

    // ---------------- core responder ----------------
    initial begin
        logic [63:0] r;
        i_core_valid = 1'b0;
        i_core_re    = '0;
        i_core_im    = '0;
        forever begin
            @(negedge clk);
            if (o_core_last && core_delay > 0 && rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                repeat (core_delay) @(posedge clk);
                #1;
                i_core_valid = 1'b1;
                i_core_re    = r[63:32];
                i_core_im    = r[31:0];
                @(posedge clk);
                #1;
                i_core_valid = 1'b0;
                ovr_log.push_back(o_overrun);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int frames);
        step();
        i_frames = FW'(frames);
        i_start  = 1'b1;
        step();
        i_start  = 1'b0;
    endtask

    // Feed samples (valid every gap-th cycle) until the run ends.
    task automatic run_frames(input int frames, input int gap);
        int c;
        start_run(frames);
        for (c = 0; c < 5000; c++) begin
            i_sample       = IW'($urandom_range(0, 4095));
            i_sample_valid = (c % gap) == 0;
            step();
            if (!o_busy) break;
        end
        i_sample_valid = 1'b0;
        check_vec("run_bound", 64'(o_busy), 64'(0));
        repeat (3) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_frames = '0;
        i_sample = '0; i_sample_valid = 1'b0; i_res_ready = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        step();

        // Reset state
        check_vec("rst_busy", 64'(o_busy), 64'(0));
        check_vec("rst_res_valid", 64'(o_res_valid), 64'(0));
        check_vec("rst_ready", 64'(o_sample_ready), 64'(0));
        check_vec("rst_clr", 64'(o_core_clr), 64'(0));
        check_vec("rst_flags", {61'd0, o_done, o_overrun, o_timeout}, 64'(0));

        // Two frames, always-valid source, consumer always ready
        clear_stats();
        core_delay = 2;
        rsp_q.push_back({32'd5, 32'd7});  exp_q.push_back({32'd5, 32'd7});
        rsp_q.push_back({32'd9, 32'd11}); exp_q.push_back({32'd9, 32'd11});
        run_frames(2, 1);
        check_vec("t1_acc", 64'(acc_cnt), 64'(252));
        check_vec("t1_clr", 64'(clr_cnt), 64'(2));
        check_vec("t1_last", 64'(last_cnt), 64'(2));
        check_vec("t1_pops", 64'(pop_cnt), 64'(2));
        check_vec("t1_done", 64'(done_cnt), 64'(1));
        check_vec("t1_done_after", 64'(done_pops), 64'(2));
        check_vec("t1_expq", 64'(exp_q.size()), 64'(0));

        // Gapped source, one frame
        clear_stats();
        rsp_q.push_back({32'd100, 32'hFFFF_FFFD}); exp_q.push_back({32'd100, 32'hFFFF_FFFD});
        run_frames(1, 3);
        check_vec("t2_acc", 64'(acc_cnt), 64'(126));
        check_vec("t2_last", 64'(last_cnt), 64'(1));
        check_vec("t2_done", 64'(done_cnt), 64'(1));
        check_vec("t2_pops", 64'(pop_cnt), 64'(1));

        // Consumer stalled: first result kept, later ones dropped
        clear_stats();
        i_res_ready = 1'b0;
        rsp_q.push_back({32'd21, 32'd22});
        rsp_q.push_back({32'd31, 32'd32});
        rsp_q.push_back({32'd41, 32'd42});
        exp_q.push_back({32'd21, 32'd22});
        run_frames(3, 1);
        check_vec("t3_ovr_log_n", 64'(ovr_log.size()), 64'(3));
        if (ovr_log.size() >= 2) begin
            check_vec("t3_ovr_after1", 64'(ovr_log[0]), 64'(0));
            check_vec("t3_ovr_after2", 64'(ovr_log[1]), 64'(1));
        end
        check_vec("t3_overrun", 64'(o_overrun), 64'(1));
        check_vec("t3_res_valid", 64'(o_res_valid), 64'(1));
        check_vec("t3_res_re", 64'(o_res_re), 64'(21));
        check_vec("t3_res_im", 64'(o_res_im), 64'(22));
        check_vec("t3_done", 64'(done_cnt), 64'(1));
        i_res_ready = 1'b1;
        step();
        step();
        check_vec("t3_pops", 64'(pop_cnt), 64'(1));
        check_vec("t3_drained", 64'(o_res_valid), 64'(0));

        // Abort in the cycle of accepted sample 60, then a clean restart
        clear_stats();
        start_run(1);                    // now in CLEAR
        i_sample_valid = 1'b1;
        i_sample = IW'($urandom_range(0, 4095));
        step();                          // cycle accepting sample 1
        repeat (59) begin
            i_sample = IW'($urandom_range(0, 4095));
            step();
        end
        i_abort = 1'b1;
        #1;
        check_vec("t4_abort_no_en", 64'(o_core_en), 64'(0));
        check_vec("t4_abort_no_ready", 64'(o_sample_ready), 64'(0));
        step();
        i_abort = 1'b0;
        i_sample_valid = 1'b0;
        #1;
        check_vec("t4_busy", 64'(o_busy), 64'(0));
        check_vec("t4_clr", 64'(o_core_clr), 64'(1));
        step();
        check_vec("t4_clr_once", 64'(o_core_clr), 64'(0));
        check_vec("t4_acc", 64'(acc_cnt), 64'(59));
        check_vec("t4_done", 64'(done_cnt), 64'(0));
        clear_stats();
        rsp_q.push_back({32'd7, 32'd8}); exp_q.push_back({32'd7, 32'd8});
        run_frames(1, 1);
        check_vec("t4_restart_acc", 64'(acc_cnt), 64'(126));
        check_vec("t4_restart_last", 64'(last_cnt), 64'(1));
        check_vec("t4_restart_done", 64'(done_cnt), 64'(1));

        // Core never answers
        clear_stats();
        core_delay = 0;
        run_frames(1, 1);
        check_vec("t5_timeout", 64'(o_timeout), 64'(1));
        check_vec("t5_to_delay", 64'(to_cyc - last_cyc), 64'(CORE_TO));
        check_vec("t5_done", 64'(done_cnt), 64'(0));
        check_vec("t5_busy", 64'(o_busy), 64'(0));
        start_run(1);
        check_vec("t5_start_clears", 64'(o_timeout), 64'(0));
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        step();

        // Reset in mid-ACCUM with a full result buffer
        clear_stats();
        core_delay = 2;
        i_res_ready = 1'b0;
        rsp_q.push_back({32'd55, 32'd66});
        start_run(2);
        i_sample_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            i_sample = IW'($urandom_range(1, 4095));
            step();
            if (o_res_valid && o_sample_ready) break;
        end
        check_vec("t6_setup", 64'({o_res_valid, o_sample_ready}), 64'(3));
        repeat (10) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        #1;
        check_vec("t6_res", {o_res_valid, o_res_re, o_res_im}, 64'(0));
        check_vec("t6_ctrl", 64'({o_busy, o_sample_ready, o_core_en, o_core_clr, o_core_last}), 64'(0));
        check_vec("t6_core_sample", 64'(o_core_sample), 64'(0));
        check_vec("t6_flags", 64'({o_done, o_overrun, o_timeout}), 64'(0));
        i_sample_valid = 1'b0;
        i_res_ready = 1'b1;

        // Start together with abort is refused
        i_start = 1'b1;
        i_abort = 1'b1;
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        #1;
        check_vec("t6_start_abort_busy", 64'(o_busy), 64'(0));
        check_vec("t6_start_abort_clr", 64'(o_core_clr), 64'(0));
        step();
        check_vec("t6_still_idle", 64'(o_busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
